// File: rtl/tlc_signal_monitor.sv
// Consumer-side checker for the traffic light controller's highway/farm light codes.
// Tracks per-road code, dwell and first-segment history and latches sticky faults.
module tlc_signal_monitor #(
    parameter int unsigned CNT_W      = 31,
    parameter int unsigned MIN_GREEN  = 1500000000,
    parameter int unsigned MIN_YELLOW = 300000000,
    parameter int unsigned MIN_ALLRED = 100000000
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [1:0] highwaySignal,
    input  logic [1:0] farmSignal,
    input  logic       Clr,
    output logic       fault,
    output logic [4:0] fault_flags,
    output logic [1:0] fault_road,
    output logic [1:0] state
);

    localparam logic [1:0] CODE_G = 2'b00;
    localparam logic [1:0] CODE_Y = 2'b01;
    localparam logic [1:0] CODE_R = 2'b10;
    localparam logic [1:0] CODE_X = 2'b11;

    localparam logic [CNT_W-1:0] MIN_GREEN_W  = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] MIN_YELLOW_W = CNT_W'(MIN_YELLOW);
    localparam logic [CNT_W-1:0] MIN_ALLRED_W = CNT_W'(MIN_ALLRED);
    localparam logic [CNT_W-1:0] DWELL_MAX    = '1;
    localparam logic [CNT_W-1:0] DWELL_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_INIT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FAULT = 2'b10
    } state_e;

    state_e state_q;
    state_e state_d;

    logic [1:0]       hw_prev_q;
    logic [CNT_W-1:0] hw_dwell_q;
    logic             hw_first_q;
    logic [1:0]       farm_prev_q;
    logic [CNT_W-1:0] farm_dwell_q;
    logic             farm_first_q;

    logic [3:0] hw_viol;
    logic [3:0] farm_viol;
    logic       conflict;
    logic [4:0] new_flags;
    logic [1:0] new_road;
    logic [4:0] flags_d;
    logic [1:0] road_d;

    // Per-road violations returned as {illegal, sequence, timing, clearance}
    function automatic logic [3:0] road_check(
        input logic [1:0]       cur,
        input logic [1:0]       prev,
        input logic [CNT_W-1:0] dwell,
        input logic             first,
        input logic [1:0]       o_prev,
        input logic [CNT_W-1:0] o_dwell,
        input logic             o_first
    );
        logic illegal;
        logic seq;
        logic timing;
        logic clear;
        illegal = (cur == CODE_X);
        seq     = 1'b0;
        timing  = 1'b0;
        clear   = 1'b0;
        if (cur != prev) begin
            if (prev == CODE_G && cur == CODE_Y) begin
                timing = !first && (dwell < MIN_GREEN_W);
            end else if (prev == CODE_Y && cur == CODE_R) begin
                timing = !first && (dwell < MIN_YELLOW_W);
            end else if (prev == CODE_R && cur == CODE_G) begin
                // Other road's red dwell is only trusted once it has a known history
                clear = (o_prev != CODE_R) || (!o_first && (o_dwell < MIN_ALLRED_W));
            end else begin
                seq = 1'b1;
            end
        end
        return {illegal, seq, timing, clear};
    endfunction

    // Violation detection on the current sample
    always_comb begin
        hw_viol   = '0;
        farm_viol = '0;
        conflict  = 1'b0;
        if (state_q != ST_INIT) begin
            hw_viol   = road_check(highwaySignal, hw_prev_q, hw_dwell_q, hw_first_q,
                                   farm_prev_q, farm_dwell_q, farm_first_q);
            farm_viol = road_check(farmSignal, farm_prev_q, farm_dwell_q, farm_first_q,
                                   hw_prev_q, hw_dwell_q, hw_first_q);
            conflict  = (highwaySignal != CODE_R) && (farmSignal != CODE_R);
        end
        new_flags = {conflict,
                     hw_viol[3] | farm_viol[3],
                     hw_viol[2] | farm_viol[2],
                     hw_viol[1] | farm_viol[1],
                     hw_viol[0] | farm_viol[0]};
        new_road  = {conflict | (|farm_viol), conflict | (|hw_viol)};
    end

    // Next-state and sticky flag update; a new violation wins over Clr
    always_comb begin
        state_d = state_q;
        flags_d = fault_flags | new_flags;
        road_d  = fault_road | new_road;
        if (Clr && state_q != ST_INIT) begin
            flags_d = new_flags;
            road_d  = new_road;
        end
        case (state_q)
            ST_INIT:  state_d = ST_RUN;
            ST_RUN:   if (flags_d != '0) state_d = ST_FAULT;
            ST_FAULT: if (Clr && new_flags == '0) state_d = ST_RUN;
            default:  state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            fault_flags <= '0;
            fault_road  <= '0;
            fault       <= 1'b0;
        end else begin
            fault_flags <= flags_d;
            fault_road  <= road_d;
            fault       <= |flags_d;
        end
    end

    // Highway code/dwell tracking
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            hw_prev_q  <= CODE_R;
            hw_dwell_q <= '0;
            hw_first_q <= 1'b1;
        end else if (state_q == ST_INIT) begin
            hw_prev_q  <= highwaySignal;
            hw_dwell_q <= DWELL_ONE;
        end else if (highwaySignal != hw_prev_q) begin
            hw_prev_q  <= highwaySignal;
            hw_dwell_q <= DWELL_ONE;
            hw_first_q <= 1'b0;
        end else if (hw_dwell_q != DWELL_MAX) begin
            hw_dwell_q <= hw_dwell_q + DWELL_ONE;
        end
    end

    // Farm code/dwell tracking
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            farm_prev_q  <= CODE_R;
            farm_dwell_q <= '0;
            farm_first_q <= 1'b1;
        end else if (state_q == ST_INIT) begin
            farm_prev_q  <= farmSignal;
            farm_dwell_q <= DWELL_ONE;
        end else if (farmSignal != farm_prev_q) begin
            farm_prev_q  <= farmSignal;
            farm_dwell_q <= DWELL_ONE;
            farm_first_q <= 1'b0;
        end else if (farm_dwell_q != DWELL_MAX) begin
            farm_dwell_q <= farm_dwell_q + DWELL_ONE;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_tlc_signal_monitor.sv
// Directed bench for tlc_signal_monitor with short phase minimums (8/4/2).
module tb_tlc_signal_monitor;

    localparam logic [1:0] G = 2'b00;
    localparam logic [1:0] Y = 2'b01;
    localparam logic [1:0] R = 2'b10;
    localparam logic [1:0] X = 2'b11;

    logic       Clk = 1'b0;
    logic       Rst;
    logic [1:0] highwaySignal;
    logic [1:0] farmSignal;
    logic       Clr;
    logic       fault;
    logic [4:0] fault_flags;
    logic [1:0] fault_road;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;

    tlc_signal_monitor #(
        .CNT_W     (31),
        .MIN_GREEN (8),
        .MIN_YELLOW(4),
        .MIN_ALLRED(2)
    ) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .highwaySignal(highwaySignal),
        .farmSignal   (farmSignal),
        .Clr          (Clr),
        .fault        (fault),
        .fault_flags  (fault_flags),
        .fault_road   (fault_road),
        .state        (state)
    );

    always #5 Clk = ~Clk;

    // Apply one sample, let it be clocked, settle 1 time unit past the edge
    task automatic cyc(input logic [1:0] hw, input logic [1:0] fm, input logic clr);
        highwaySignal = hw;
        farmSignal    = fm;
        Clr           = clr;
        @(posedge Clk);
        #1;
        Clr = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b0; highwaySignal = R; farmSignal = R; Clr = 1'b0;
        @(posedge Clk); @(posedge Clk); #1;
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state got=%b exp=00", state); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b exp=0", fault); end
        checks++; if (fault_flags !== 5'b00000) begin errors++; $display("FAIL reset_flags got=%b exp=00000", fault_flags); end
        checks++; if (fault_road !== 2'b00) begin errors++; $display("FAIL reset_road got=%b exp=00", fault_road); end
        #3 Rst = 1'b1;
        #1;
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL init_state got=%b exp=00", state); end
        cyc(R, R, 1'b0);
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL run_state got=%b exp=01", state); end
        cyc(R, R, 1'b0);
        cyc(R, R, 1'b0);
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL idle_fault got=%b exp=0", fault); end
        checks++; if (fault_flags !== 5'b00000) begin errors++; $display("FAIL idle_flags got=%b exp=00000", fault_flags); end
    endtask

    task automatic test_legal_cycle();
        logic [1:0] hw_seq [15];
        logic [1:0] fm_seq [15];
        for (int i = 0; i < 15; i++) begin
            hw_seq[i] = (i < 8) ? G : (i < 12) ? Y : R;
            fm_seq[i] = (i == 14) ? G : R;
        end
        for (int i = 0; i < 15; i++) begin
            cyc(hw_seq[i], fm_seq[i], 1'b0);
            checks++;
            if (fault !== 1'b0 || fault_flags !== 5'b00000) begin
                errors++;
                $display("FAIL legal_cycle step=%0d fault=%b flags=%b exp fault=0 flags=00000", i, fault, fault_flags);
            end
        end
    endtask

    task automatic test_timing();
        repeat (7) cyc(R, G, 1'b0);
        repeat (4) cyc(R, Y, 1'b0);
        repeat (2) cyc(R, R, 1'b0);
        repeat (7) cyc(G, R, 1'b0);
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL timing_pre_fault got=%b exp=0", fault); end
        cyc(Y, R, 1'b0);
        checks++; if (fault_flags !== 5'b00010) begin errors++; $display("FAIL timing_flags got=%b exp=00010", fault_flags); end
        checks++; if (fault_road !== 2'b01) begin errors++; $display("FAIL timing_road got=%b exp=01", fault_road); end
        checks++; if (state !== 2'b10) begin errors++; $display("FAIL timing_state got=%b exp=10", state); end
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL timing_fault got=%b exp=1", fault); end
        cyc(Y, R, 1'b1);
        checks++; if (fault_flags !== 5'b00000) begin errors++; $display("FAIL clr_flags got=%b exp=00000", fault_flags); end
        checks++; if (fault_road !== 2'b00) begin errors++; $display("FAIL clr_road got=%b exp=00", fault_road); end
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL clr_state got=%b exp=01", state); end
    endtask

    task automatic test_conflict();
        repeat (2) cyc(Y, R, 1'b0);
        repeat (2) cyc(R, R, 1'b0);
        repeat (8) cyc(R, G, 1'b0);
        cyc(R, Y, 1'b0);
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL conflict_pre_fault got=%b exp=0", fault); end
        cyc(G, Y, 1'b0);
        checks++; if (fault_flags !== 5'b10001) begin errors++; $display("FAIL conflict_flags got=%b exp=10001", fault_flags); end
        checks++; if (fault_road !== 2'b11) begin errors++; $display("FAIL conflict_road got=%b exp=11", fault_road); end
        cyc(R, Y, 1'b1);
        checks++; if (fault_flags !== 5'b00100) begin errors++; $display("FAIL seq_flags got=%b exp=00100", fault_flags); end
        checks++; if (fault_road !== 2'b01) begin errors++; $display("FAIL seq_road got=%b exp=01", fault_road); end
        checks++; if (state !== 2'b10) begin errors++; $display("FAIL seq_state got=%b exp=10", state); end
        cyc(R, Y, 1'b1);
        checks++; if (state !== 2'b01 || fault_flags !== 5'b00000) begin
            errors++; $display("FAIL seq_clear state=%b flags=%b exp state=01 flags=00000", state, fault_flags);
        end
    endtask

    task automatic test_illegal_code();
        cyc(R, X, 1'b0);
        checks++; if (fault_flags !== 5'b01100) begin errors++; $display("FAIL illegal_flags got=%b exp=01100", fault_flags); end
        checks++; if (fault_road !== 2'b10) begin errors++; $display("FAIL illegal_road got=%b exp=10", fault_road); end
        cyc(R, R, 1'b0);
        checks++; if (fault_flags !== 5'b01100) begin errors++; $display("FAIL illegal_exit_flags got=%b exp=01100", fault_flags); end
        checks++; if (fault_road !== 2'b10) begin errors++; $display("FAIL illegal_exit_road got=%b exp=10", fault_road); end
        cyc(R, R, 1'b0);
        cyc(G, G, 1'b1);
        checks++; if (fault_flags !== 5'b10000) begin errors++; $display("FAIL set_beats_clear_flags got=%b exp=10000", fault_flags); end
        checks++; if (fault_road !== 2'b11) begin errors++; $display("FAIL set_beats_clear_road got=%b exp=11", fault_road); end
        checks++; if (state !== 2'b10) begin errors++; $display("FAIL set_beats_clear_state got=%b exp=10", state); end
    endtask

    task automatic test_reset_mid();
        #3 Rst = 1'b0;
        highwaySignal = G;
        farmSignal    = R;
        #1;
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL mid_reset_state got=%b exp=00", state); end
        checks++; if (fault !== 1'b0 || fault_flags !== 5'b00000 || fault_road !== 2'b00) begin
            errors++; $display("FAIL mid_reset_outputs fault=%b flags=%b road=%b exp all zero", fault, fault_flags, fault_road);
        end
        @(posedge Clk);
        #4 Rst = 1'b1;
        repeat (2) cyc(G, R, 1'b0);
        cyc(Y, R, 1'b0);
        checks++; if (fault_flags !== 5'b00000) begin errors++; $display("FAIL restart_flags got=%b exp=00000", fault_flags); end
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL restart_state got=%b exp=01", state); end
    endtask

    initial begin
        test_reset();
        test_legal_cycle();
        test_timing();
        test_conflict();
        test_illegal_code();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
